video_trans_eth_arp_ctrl: RTL
=============================

// Module: video_trans_eth_arp_ctrl
// PURPOSE
//  ARP control stage that sits directly downstream of the ARP receive path and upstream of the ARP transmit path.
//  Answers inbound ARP requests with replies.
//  Resolves the host MAC with periodic ARP requests until a reply from DES_IP arrives.
//  Holds the resolved peer MAC/IP for the UDP video path.
//  Arbitrates ARP transmission against the UDP sender via udp_tx_busy.
//  clk is the common GMII clock; gmii_rx_clk and gmii_tx_clk share one source in this design.
// PARAMETERS
//  DES_IP        {192,168,1,102}  host IP to resolve; only replies from this IP update the peer
//  RETRY_CYCLES  125_000_000      cycles between ARP requests while unresolved (1 s at 125 MHz)
//  TX_TIMEOUT    4096             cycles to wait for tx_done before abandoning a transmission
// PORTS
//  clk          in   1   GMII clock
//  rst_n        in   1   asynchronous reset, active low
//  start        in   1   1-cycle pulse: request resolution now (also arms periodic retry)
//  arp_rx_done  in   1   1-cycle pulse: ARP packet received for BOARD_IP
//  arp_rx_type  in   1   0=request, 1=reply; valid with arp_rx_done
//  src_mac      in   48  sender MAC; valid with arp_rx_done
//  src_ip       in   32  sender IP; valid with arp_rx_done
//  tx_done      in   1   1-cycle pulse: Ethernet frame transmission finished
//  udp_tx_busy  in   1   UDP sender owns GMII TX; ARP must not start
//  arp_tx_en    out  1   1-cycle pulse: start ARP frame
//  arp_tx_type  out  1   0=request, 1=reply; stable from arp_tx_en to tx_done
//  des_mac      out  48  destination MAC; stable from arp_tx_en to tx_done
//  des_ip       out  32  destination IP; stable from arp_tx_en to tx_done
//  arp_busy     out  1   1 in SEND and WAIT_DONE states
//  peer_valid   out  1   peer resolved
//  peer_mac     out  48  resolved host MAC
//  peer_ip      out  32  resolved host IP
//  tx_err       out  1   1-cycle pulse on TX_TIMEOUT expiry
// BEHAVIOUR
//  - Reset value of every output is 0, including des_mac/des_ip/peer_*. Reset mid-frame drops all pending work.
//  - Inbound request (arp_rx_done & !arp_rx_type): latch src_mac/src_ip into the reply slot; set rply_pend next cycle.
//    The reply slot is single-entry and the newest request overwrites it.
//  - Inbound reply (arp_rx_done & arp_rx_type & src_ip==DES_IP): peer_mac<=src_mac, peer_ip<=src_ip, peer_valid<=1 next cycle.
//    The same update clears req_pend and stops the retry timer. Replies from any other IP are ignored.
//  - start: sets req_pend and clears peer_valid.
//    Retry timer counts 0..RETRY_CYCLES-1 while !peer_valid and armed; at wrap it sets req_pend.
//    start restarts the count at 0.
//  - FSM: IDLE -> SEND when (rply_pend|req_pend) & !udp_tx_busy. Reply has priority over request.
//    SEND (1 cycle): drive arp_tx_en=1 and load type/des_mac/des_ip, then go to WAIT_DONE.
//      Reply: type=1, des = reply slot.
//      Request: type=0, des_mac=48'hFFFF_FFFF_FFFF, des_ip=DES_IP.
//      The served pending flag clears here.
//    WAIT_DONE -> IDLE on tx_done.
//    WAIT_DONE -> IDLE on timeout counter reaching TX_TIMEOUT-1, with tx_err pulse; the served flag is not re-set.
//  - Latency: arp_rx_done(request) at cycle N with FSM idle and bus free gives arp_tx_en at N+2.
//  - udp_tx_busy only gates the IDLE->SEND transition; once in SEND/WAIT_DONE it is ignored.
//  - Simultaneous events:
//    - A request received while in SEND/WAIT_DONE is queued (slot updated), never corrupts des_*.
//    - start coinciding with a peer-matching reply: reply wins, peer_valid=1, req_pend=0.
//    - Retry wrap while req_pend is already set: no effect.
//  - tx_done outside WAIT_DONE is ignored.
// STRUCTURE
//  - Package video_trans_eth_pkg: ARP_REQ=1'b0, ARP_REPLY=1'b1, MAC_BCAST=48'hFFFF_FFFF_FFFF, FSM state encoding.
//  - Sub-module video_trans_eth_arp_retry_tmr: retry counter with inputs restart and run, output 1-cycle wrap pulse.
//  - Everything else (slots, FSM, timeout counter) lives in this module.
// TESTING
//  - Reset, then request from 10.0.0.5 / 02:00:00:00:00:05 -> arp_tx_en at N+2, type=1, des_mac=02:00:00:00:00:05, des_ip=10.0.0.5.
//  - start, no reply (RETRY_CYCLES=100) -> broadcast requests to DES_IP at start+2 and every 100 cycles after.
//    Reply from 192.168.1.102 -> peer_valid=1, no further requests.
//  - Reply from 192.168.1.7 -> peer unchanged; request and reply both pending -> reply sent first, request immediately after its tx_done.
//  - udp_tx_busy=1 for 500 cycles with a request pending -> no arp_tx_en until 1 cycle after udp_tx_busy falls.
//  - Withhold tx_done (TX_TIMEOUT=64) -> tx_err pulse 64 cycles after SEND, FSM back in IDLE.
//    Assert rst_n low in WAIT_DONE -> all outputs 0 and nothing sent after release.

Source files
------------

// File: rtl/video_trans_eth_pkg.sv
// Shared ARP constants and control FSM encoding for the Ethernet video transport.
package video_trans_eth_pkg;

  localparam logic        ARP_REQ   = 1'b0;
  localparam logic        ARP_REPLY = 1'b1;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arp_state_e;

endpackage

// File: rtl/video_trans_eth_arp_retry_tmr.sv
// Free-running retry interval counter; emits a 1-cycle wrap pulse every RETRY_CYCLES
// cycles of run, restarted from zero by restart.
module video_trans_eth_arp_retry_tmr #(
  parameter int unsigned RETRY_CYCLES = 125_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic wrap
);

  localparam int unsigned      CNT_W    = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RETRY_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign wrap = run & ~restart & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/video_trans_eth_arp_ctrl.sv
// ARP control: answers inbound requests, resolves DES_IP with periodic requests and
// arbitrates ARP frames against the UDP sender on the shared GMII transmitter.
module video_trans_eth_arp_ctrl
  import video_trans_eth_pkg::*;
#(
  parameter logic [31:0] DES_IP       = {8'd192, 8'd168, 8'd1, 8'd102},
  parameter int unsigned RETRY_CYCLES = 125_000_000,
  parameter int unsigned TX_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        tx_done,
  input  logic        udp_tx_busy,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  output logic        arp_busy,
  output logic        peer_valid,
  output logic [47:0] peer_mac,
  output logic [31:0] peer_ip,
  output logic        tx_err
);

  localparam int unsigned     TO_W    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TX_TIMEOUT - 1);

  arp_state_e      state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [47:0]     rply_mac;
  logic [31:0]     rply_ip;
  logic            rply_pend, req_pend, armed;
  logic            load_tx, serve_rply, serve_req, retry_wrap;
  logic            rx_req, rx_peer_rply;

  assign rx_req       = arp_rx_done & (arp_rx_type == ARP_REQ);
  assign rx_peer_rply = arp_rx_done & (arp_rx_type == ARP_REPLY) & (src_ip == DES_IP);
  assign arp_tx_en    = (state == ST_SEND);
  assign arp_busy     = (state != ST_IDLE);

  video_trans_eth_arp_retry_tmr #(
    .RETRY_CYCLES(RETRY_CYCLES)
  ) u_retry_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(start),
    .run    (armed & ~peer_valid),
    .wrap   (retry_wrap)
  );

  // Single-entry reply slot: newest request overwrites, no reset needed on data.
  always_ff @(posedge clk) begin
    if (rx_req) begin
      rply_mac <= src_mac;
      rply_ip  <= src_ip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      rply_pend   <= 1'b0;
      req_pend    <= 1'b0;
      armed       <= 1'b0;
      peer_valid  <= 1'b0;
      peer_mac    <= '0;
      peer_ip     <= '0;
      arp_tx_type <= 1'b0;
      des_mac     <= '0;
      des_ip      <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= (state == ST_WAIT_DONE) ? to_cnt + TO_W'(1) : '0;

      // New events win over the clear from the transmission being launched.
      if (rx_req)          rply_pend <= 1'b1;
      else if (serve_rply) rply_pend <= 1'b0;

      if (rx_peer_rply)              req_pend <= 1'b0;
      else if (start || retry_wrap)  req_pend <= 1'b1;
      else if (serve_req)            req_pend <= 1'b0;

      if (rx_peer_rply) begin
        armed      <= 1'b0;
        peer_valid <= 1'b1;
        peer_mac   <= src_mac;
        peer_ip    <= src_ip;
      end else if (start) begin
        armed      <= 1'b1;
        peer_valid <= 1'b0;
      end

      if (load_tx) begin
        arp_tx_type <= serve_rply ? ARP_REPLY : ARP_REQ;
        des_mac     <= serve_rply ? rply_mac  : MAC_BCAST;
        des_ip      <= serve_rply ? rply_ip   : DES_IP;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    load_tx    = 1'b0;
    serve_rply = 1'b0;
    serve_req  = 1'b0;
    tx_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((rply_pend || req_pend) && !udp_tx_busy) begin
          state_nxt  = ST_SEND;
          load_tx    = 1'b1;
          serve_rply = rply_pend;
          serve_req  = ~rply_pend;
        end
      end
      ST_SEND:      state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_nxt = ST_IDLE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = ST_IDLE;
          tx_err    = 1'b1;
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

endmodule
